// File: rtl/common_bus_pkg.sv
// Shared types and helpers for the parametrised common-bus datapath.
// Holds the memory FSM state encoding and the bus-select code helpers.
package common_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } mem_state_e;

    localparam int SEL_ZERO = 0;

    // Bus-select code of the memory data register for a given register count.
    function automatic int sel_mdr(input int num_reg);
        return num_reg + 1;
    endfunction

    // $clog2 returns 0 for a single code; a select port needs at least one bit.
    function automatic int sel_width(input int num_codes);
        return (num_codes <= 2) ? 1 : $clog2(num_codes);
    endfunction

endpackage

// File: rtl/bus_reg_cell.sv
// One common-bus register: clear beats load beats increment.
// wrap pulses for one cycle only when an increment rolls all-ones over to zero.
module bus_reg_cell #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              ld,
    input  logic              inr,
    input  logic [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] q,
    output logic              wrap
);

    // NOTE: sequential state uses <= so every cell samples the bus value from before this edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                q <= '0;
            end else if (ld) begin
                q <= bus;
            end else if (inr) begin
                q    <= q + 1'b1;
                wrap <= &q;
            end
        end
    end

endmodule

// File: rtl/common_bus_datapath_p.sv
// Common-bus datapath core: NUM_REG registers on one bus, plus a banked memory
// behind a request/done handshake with MEM_WAIT programmable wait states.
module common_bus_datapath_p
    import common_bus_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 12,
    parameter int NUM_REG  = 6,
    parameter int AR_IDX   = 0,
    parameter int MEM_WAIT = 1,
    parameter int SEL_W    = sel_width(NUM_REG + 2)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [SEL_W-1:0]   select,
    input  logic [NUM_REG-1:0] ld,
    input  logic [NUM_REG-1:0] clr,
    input  logic [NUM_REG-1:0] inr,
    input  logic               mem_rd,
    input  logic               mem_wr,
    output logic               mem_busy,
    output logic               mem_done,
    output logic               mem_err,
    output logic [DATA_W-1:0]  bus_out,
    output logic [NUM_REG-1:0] inr_wrap
);

    localparam int MEM_DEPTH = 2 ** ADDR_W;
    localparam int CNT_W     = 4;

    logic [DATA_W-1:0] reg_q [NUM_REG];
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] mem   [MEM_DEPTH];

    mem_state_e        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              access_last;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              is_wr;
    logic              req;
    logic              commit_wr;

    for (genvar i = 0; i < NUM_REG; i++) begin : g_reg
        bus_reg_cell #(.DATA_W(DATA_W)) u_cell (
            .clock (clock),
            .reset (reset),
            .clr   (clr[i]),
            .ld    (ld[i]),
            .inr   (inr[i]),
            .bus   (bus_out),
            .q     (reg_q[i]),
            .wrap  (inr_wrap[i])
        );
    end

    // NOTE: the default assignment first keeps this block a pure mux with no latch.
    always_comb begin
        bus_out = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            if (select == SEL_W'(i + 1)) bus_out = reg_q[i];
        end
        if (select == SEL_W'(sel_mdr(NUM_REG))) bus_out = mdr;
    end

    assign req = mem_rd | mem_wr;

    // ACCESS spans two cycles: RAM read registration, then completion with mem_done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            access_last <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            is_wr       <= 1'b0;
            mdr         <= '0;
            mem_busy    <= 1'b0;
            mem_done    <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q      <= reg_q[AR_IDX][ADDR_W-1:0];
                        wdata_q     <= bus_out;
                        is_wr       <= ~mem_rd;
                        mem_err     <= mem_rd & mem_wr;
                        mem_busy    <= 1'b1;
                        wait_cnt    <= '0;
                        access_last <= 1'b0;
                        state       <= (MEM_WAIT > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    mem_err <= req;
                    if (wait_cnt == CNT_W'(MEM_WAIT - 1)) state <= ST_ACCESS;
                    else wait_cnt <= wait_cnt + 1'b1;
                end
                ST_ACCESS: begin
                    mem_err <= req;
                    if (!access_last) begin
                        rdata_q     <= mem[addr_q];
                        access_last <= 1'b1;
                    end else begin
                        if (!is_wr) mdr <= rdata_q;
                        mem_done    <= 1'b1;
                        mem_busy    <= 1'b0;
                        access_last <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign commit_wr = (state == ST_ACCESS) && access_last && is_wr;

    // NOTE: the memory array is never reset; an aborted access is blocked by the FSM instead.
    always_ff @(posedge clock) begin
        if (commit_wr && !reset) mem[addr_q] <= wdata_q;
    end

endmodule

// File: doc/common_bus_datapath_p.md
Name: common_bus_datapath_p

Overview:
- Parametrised successor to the team's fixed six-register common-bus datapath.
- NUM_REG general registers share one DATA_W-wide common bus, with per-register load, clear and increment controls.
- Adds a banked main memory behind a request/done handshake with programmable wait states, plus error reporting for illegal requests.
- Sits between the control sequencer (which drives select/control vectors) and the memory; it is the datapath core of the basic computer.

Parameters:
- DATA_W, 16, width of the bus, the registers and the memory words.
- ADDR_W, 12, memory address width; memory depth is 2**ADDR_W words.
- NUM_REG, 6, number of bus registers (minimum 2).
- AR_IDX, 0, index of the register whose low ADDR_W bits address memory.
- MEM_WAIT, 1, extra wait cycles per memory access (0..15).
- SEL_W, $clog2(NUM_REG+2), width of the bus-source select.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- select  in  SEL_W  bus source: 0 = zero; 1..NUM_REG = reg[select-1]; NUM_REG+1 = mdr; codes above that = zero.
- ld  in  NUM_REG  load reg[i] from the bus.
- clr  in  NUM_REG  clear reg[i] to 0.
- inr  in  NUM_REG  increment reg[i].
- mem_rd  in  1  read request, single-cycle pulse.
- mem_wr  in  1  write request, single-cycle pulse.
- mem_busy  out  1  high while an access is in flight.
- mem_done  out  1  one-cycle pulse when an access completes.
- mem_err  out  1  one-cycle pulse on an illegal request.
- bus_out  out  DATA_W  current common-bus value (combinational from select).
- inr_wrap  out  NUM_REG  one-cycle pulse when reg[i] increments from all-ones to 0.

Behaviour:
- Reset (asynchronous): all registers, mdr, FSM state, mem_busy, mem_done, mem_err and inr_wrap go to 0. Memory contents are not reset. A reset mid-access aborts it: no write is committed and no mem_done is produced.
- The bus is combinational from select; there is no bus register. ld captures bus_out at the same edge.
- Per-register priority when several controls are asserted in one cycle: clr > ld > inr. The lower-priority actions are dropped silently, and inr_wrap is not raised unless inr actually takes effect.
- Increment wraps modulo 2**DATA_W.
- Memory FSM states: IDLE, WAIT, ACCESS.
  - IDLE, with exactly one of mem_rd/mem_wr high: latch addr = reg[AR_IDX][ADDR_W-1:0] and, for writes, wdata = bus_out, both sampled before that edge's register updates. Go to WAIT if MEM_WAIT > 0, else ACCESS. mem_busy rises the cycle after the request.
  - WAIT: count MEM_WAIT cycles, then go to ACCESS.
  - ACCESS: a read sets mdr <= mem[addr]; a write sets mem[addr] <= wdata. Pulse mem_done and return to IDLE. mem_busy falls with mem_done.
- Request-to-done latency is MEM_WAIT+2 cycles, counted from the request edge to the edge at which mem_done is asserted.
- Back-to-back: a new request is accepted in the cycle mem_done is high.
- mem_rd and mem_wr high together in IDLE: the read proceeds, the write is dropped, and mem_err pulses.
- Any request while mem_busy: ignored and mem_err pulses. The in-flight access is unaffected.
- Registers remain loadable during an access. Changing reg[AR_IDX] after acceptance does not alter the latched address.
- mdr is writable only by a memory read; it is selectable on the bus.

Decomposition:
- Shared package common_bus_pkg holds:
  - the FSM state enum (IDLE/WAIT/ACCESS);
  - localparams SEL_ZERO = 0 and SEL_MDR(NUM_REG) = NUM_REG+1;
  - a clog2-safe select-width function.
- One sub-module, bus_reg_cell: a single DATA_W register with clr/ld/inr priority and wrap pulse, instantiated NUM_REG times in a generate loop.
- The bus multiplexer and memory FSM live in the top level.

Test Plan:
- Reset during WAIT of a write (MEM_WAIT=3) to address 0x010, where the location held 0x0000 before the write was issued -> registers read 0, mem_busy=0, no mem_done, memory location 0x010 still holds 0x0000 afterwards.
- Load and transfer: with select=0 and ld[0]=1, the bus is zero so reg[0] is cleared. Then load reg[2] with 0x00A5 via a held memory value, set select=3, ld[4]=1 -> reg[4]=0x00A5 next edge, and bus_out=0x00A5 while select=3.
- Priority: reg[3]=0x1234 with clr, ld (bus=0xBEEF) and inr all high -> reg[3]=0; next cycle ld and inr with bus=0xBEEF -> 0xBEEF.
- Wrap: reg[1]=0xFFFF, inr[1] -> reg[1]=0x0000 and inr_wrap[1] pulses for 1 cycle.
- Memory round trip (MEM_WAIT=2): reg[0]=0x0123, bus=0xCAFE, mem_wr -> mem_done after 4 cycles. Then mem_rd -> mdr=0xCAFE, and select=NUM_REG+1 gives bus_out=0xCAFE.
- Illegal requests: mem_rd+mem_wr together at address 0x040 -> read only, mem_err pulses, memory unchanged. A mem_rd issued while busy -> mem_err pulses and the original access completes with a single mem_done.
